// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared sizes, FSM encoding and one-hot encode helper for the register-file arbiter
package regfile_arb_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    typedef enum logic {IDLE, LOCKED} state_t;

    function automatic logic [1:0] enc4(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority picker, first set req bit scanning up from ptr with wrap
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] pick
);
    logic [1:0] idx;

    // scan from farthest to nearest so the lowest offset from ptr wins
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = 3; k >= 0; k--) begin
            idx  = ptr + 2'(k);
            pick = req[idx] ? 4'(1) << idx : pick;
        end
    end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: 4-way round-robin arbiter with lockable bursts in front of an external register file
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W    = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W    = regfile_arb_pkg::ADDR_W,
    parameter int MAX_BURST = regfile_arb_pkg::MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rf_wr_en,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [DATA_W-1:0]        rf_rdata
);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d, holder_q, holder_d, sel;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d, pick;
    logic              cont, any, rd;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    // grant selection, register-file steering and next-state for burst/pointer tracking
    always_comb begin
        cont     = rst_n && state_q == LOCKED && req[holder_q] && lock[holder_q] && beat_q < BW'(MAX_BURST);
        sel      = cont ? holder_q : enc4(pick);
        any      = rst_n && (cont || |pick);
        gnt      = any ? 4'(1) << sel : '0;
        rf_wr_en = any && we[sel];
        rf_addr  = any ? addr[int'(sel)*ADDR_W +: ADDR_W] : '0;
        rf_wdata = any ? wdata[int'(sel)*DATA_W +: DATA_W] : '0;
        rd       = any && !we[sel];
        rdata_d  = rd ? rf_rdata : rdata_q;
        rvalid_d = rd ? gnt : '0;
        state_d  = IDLE;
        ptr_d    = ptr_q;
        holder_d = holder_q;
        beat_d   = beat_q;
        if (cont) begin
            beat_d  = beat_q + 1'b1;
            state_d = beat_d == BW'(MAX_BURST) ? IDLE : LOCKED;
        end else if (any) begin
            ptr_d    = sel + 2'd1;
            holder_d = sel;
            beat_d   = BW'(1);
            state_d  = lock[sel] && MAX_BURST > 1 ? LOCKED : IDLE;
        end
    end

    // state and registered read return, cleared asynchronously so a burst is abandoned on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            holder_q <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            holder_q <= holder_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
endmodule
